// File: rtl/ahb_matrix_input_stage.sv
// Master-side input stage of the sparse AHB bus matrix: decodes the master address,
// requests the targeted output arbiter, holds the address phase until granted, and routes responses back.
module ahb_matrix_input_stage #(
    parameter int unsigned         ADDR_W = 32,
    parameter logic [ADDR_W-1:0]   BASE0  = 'h0000_0000,
    parameter logic [ADDR_W-1:0]   MASK0  = 'hE000_0000,
    parameter logic [ADDR_W-1:0]   BASE1  = 'h2000_0000,
    parameter logic [ADDR_W-1:0]   MASK1  = 'hE000_0000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    input  logic              grant0,
    input  logic              grant1,
    input  logic              hready0,
    input  logic              hready1,
    input  logic              hreadyout0,
    input  logic              hreadyout1,
    input  logic              hresp0,
    input  logic              hresp1,
    output logic              req0,
    output logic              req1,
    output logic [ADDR_W-1:0] HADDRO,
    output logic [1:0]        HTRANSO,
    output logic              HWRITEO,
    output logic [2:0]        HSIZEO,
    output logic [2:0]        HBURSTO,
    output logic [3:0]        HPROTO,
    output logic              HMASTLOCKO
);

    typedef enum logic [1:0] {T_P0, T_P1, T_DEF} tgt_e;
    typedef enum logic [1:0] {D_NONE, D_P0, D_P1, D_DEF} dsel_e;
    typedef enum logic [1:0] {E_IDLE, E_ERR1, E_ERR2} err_e;

    logic              pend_q, pend_d;
    logic              tgt_q;
    dsel_e             dsel_q, dsel_d;
    err_e              err_q;
    logic              capture;
    logic [ADDR_W-1:0] haddr_q;
    logic [1:0]        htrans_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [2:0]        hburst_q;
    logic [3:0]        hprot_q;
    logic              hmastlock_q;

    tgt_e dec;
    logic active;
    logic live_gnt;
    logic held_gnt;

    assign dec = ((HADDRS & MASK0) == BASE0) ? T_P0 :
                 ((HADDRS & MASK1) == BASE1) ? T_P1 : T_DEF;

    assign active   = HSELS & HREADYS & HTRANSS[1];
    assign live_gnt = (dec == T_P0) ? (grant0 & hready0) :
                      (dec == T_P1) ? (grant1 & hready1) : 1'b0;
    assign held_gnt = tgt_q ? (grant1 & hready1) : (grant0 & hready0);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        pend_d  = pend_q;
        dsel_d  = dsel_q;
        capture = 1'b0;
        if (pend_q) begin
            if (held_gnt) begin
                pend_d = 1'b0;
                dsel_d = tgt_q ? D_P1 : D_P0;
            end
        end else if (active) begin
            if (dec == T_DEF) begin
                dsel_d = D_DEF;
            end else if (live_gnt) begin
                dsel_d = (dec == T_P1) ? D_P1 : D_P0;
            end else begin
                // The previous data phase ended at this edge, so nothing is outstanding.
                pend_d  = 1'b1;
                dsel_d  = D_NONE;
                capture = 1'b1;
            end
        end else if (HREADYS) begin
            dsel_d = D_NONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q      <= 1'b0;
            dsel_q      <= D_NONE;
            err_q       <= E_IDLE;
            tgt_q       <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= 2'b00;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hburst_q    <= 3'b000;
            hprot_q     <= 4'b0000;
            hmastlock_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            dsel_q <= dsel_d;
            if (!pend_q && active && dec == T_DEF) begin
                err_q <= E_ERR1;
            end else begin
                case (err_q)
                    E_ERR1:  err_q <= E_ERR2;
                    default: err_q <= E_IDLE;
                endcase
            end
            if (capture) begin
                tgt_q       <= (dec == T_P1);
                haddr_q     <= HADDRS;
                htrans_q    <= HTRANSS;
                hwrite_q    <= HWRITES;
                hsize_q     <= HSIZES;
                hburst_q    <= HBURSTS;
                hprot_q     <= HPROTS;
                hmastlock_q <= HMASTLOCKS;
            end
        end
    end

    assign HADDRO     = pend_q ? haddr_q     : HADDRS;
    assign HTRANSO    = pend_q ? htrans_q    : (HSELS ? HTRANSS : 2'b00);
    assign HWRITEO    = pend_q ? hwrite_q    : HWRITES;
    assign HSIZEO     = pend_q ? hsize_q     : HSIZES;
    assign HBURSTO    = pend_q ? hburst_q    : HBURSTS;
    assign HPROTO     = pend_q ? hprot_q     : HPROTS;
    assign HMASTLOCKO = pend_q ? hmastlock_q : HMASTLOCKS;

    assign req0 = pend_q ? !tgt_q : (HSELS & HTRANSS[1] & (dec == T_P0));
    assign req1 = pend_q ?  tgt_q : (HSELS & HTRANSS[1] & (dec == T_P1));

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        if (pend_q) begin
            HREADYOUTS = 1'b0;
        end else begin
            case (dsel_q)
                D_P0: begin
                    HREADYOUTS = hreadyout0;
                    HRESPS     = hresp0;
                end
                D_P1: begin
                    HREADYOUTS = hreadyout1;
                    HRESPS     = hresp1;
                end
                D_DEF: begin
                    HREADYOUTS = (err_q != E_ERR1);
                    HRESPS     = (err_q != E_IDLE);
                end
                default: begin
                    HREADYOUTS = 1'b1;
                    HRESPS     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_matrix_input_stage.sv
// Directed bench for ahb_matrix_input_stage: a table of per-cycle vectors with
// hand-computed expectations, followed by an asynchronous-reset-while-pending sequence.
module tb_ahb_matrix_input_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS, HRESPS;
    logic        grant0, grant1, hready0, hready1;
    logic        hreadyout0, hreadyout1, hresp0, hresp1;
    logic        req0, req1;
    logic [31:0] HADDRO;
    logic [1:0]  HTRANSO;
    logic        HWRITEO;
    logic [2:0]  HSIZEO;
    logic [2:0]  HBURSTO;
    logic [3:0]  HPROTO;
    logic        HMASTLOCKO;

    int n_total = 0;
    int n_bad   = 0;

    ahb_matrix_input_stage dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .grant0(grant0), .grant1(grant1), .hready0(hready0), .hready1(hready1),
        .hreadyout0(hreadyout0), .hreadyout1(hreadyout1),
        .hresp0(hresp0), .hresp1(hresp1), .req0(req0), .req1(req1),
        .HADDRO(HADDRO), .HTRANSO(HTRANSO), .HWRITEO(HWRITEO), .HSIZEO(HSIZEO),
        .HBURSTO(HBURSTO), .HPROTO(HPROTO), .HMASTLOCKO(HMASTLOCKO)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic        rdy;
        logic        g0, g1, ro0, ro1, rs1;
        logic        e_ro, e_rs;
        logic [1:0]  e_req;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_wr;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                                input logic wr, input logic rdy, input logic g0, input logic g1,
                                input logic ro0, input logic ro1, input logic rs1,
                                input logic e_ro, input logic e_rs, input logic [1:0] e_req,
                                input logic [1:0] e_trans, input logic [31:0] e_addr, input logic e_wr);
        vec_t v;
        v.sel = sel; v.addr = addr; v.trans = trans; v.wr = wr; v.rdy = rdy;
        v.g0 = g0; v.g1 = g1; v.ro0 = ro0; v.ro1 = ro1; v.rs1 = rs1;
        v.e_ro = e_ro; v.e_rs = e_rs; v.e_req = e_req; v.e_trans = e_trans;
        v.e_addr = e_addr; v.e_wr = e_wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        HSELS = v.sel; HADDRS = v.addr; HTRANSS = v.trans; HWRITES = v.wr; HREADYS = v.rdy;
        grant0 = v.g0; grant1 = v.g1; hreadyout0 = v.ro0; hreadyout1 = v.ro1; hresp1 = v.rs1;
    endtask

    // One vector per clock: drive after the edge, compare at the falling edge, then commit.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        @(negedge HCLK);
        check($sformatf("v%0d hreadyouts", idx), {31'd0, HREADYOUTS}, {31'd0, v.e_ro});
        check($sformatf("v%0d hresps", idx), {31'd0, HRESPS}, {31'd0, v.e_rs});
        check($sformatf("v%0d req", idx), {30'd0, req1, req0}, {30'd0, v.e_req});
        check($sformatf("v%0d htranso", idx), {30'd0, HTRANSO}, {30'd0, v.e_trans});
        check($sformatf("v%0d haddro", idx), HADDRO, v.e_addr);
        check($sformatf("v%0d hwriteo", idx), {31'd0, HWRITEO}, {31'd0, v.e_wr});
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        //               sel addr          tr wr rdy g0 g1 ro0 ro1 rs1 | ro rs req    tr  addr          wr
        vecs[0]  = mk(0, 32'h0,          0, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b00, 0, 32'h0,          0);
        vecs[1]  = mk(1, 32'h2000_0010,  2, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b10, 2, 32'h2000_0010,  0);
        vecs[2]  = mk(0, 32'h0,          0, 0, 0,  1, 1, 1,  0,  0,   0, 0, 2'b00, 0, 32'h0,          0);
        vecs[3]  = mk(0, 32'h0,          0, 0, 0,  1, 1, 1,  0,  1,   0, 1, 2'b00, 0, 32'h0,          0);
        vecs[4]  = mk(0, 32'h0,          0, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b00, 0, 32'h0,          0);
        vecs[5]  = mk(1, 32'h0000_0040,  2, 1, 1,  0, 1, 1,  1,  0,   1, 0, 2'b01, 2, 32'h0000_0040,  1);
        vecs[6]  = mk(1, 32'h1234_0000,  0, 0, 0,  0, 1, 1,  1,  0,   0, 0, 2'b01, 2, 32'h0000_0040,  1);
        vecs[7]  = mk(1, 32'h2000_0000,  3, 0, 0,  0, 1, 1,  1,  0,   0, 0, 2'b01, 2, 32'h0000_0040,  1);
        vecs[8]  = mk(0, 32'h0,          0, 0, 0,  1, 1, 1,  1,  0,   0, 0, 2'b01, 2, 32'h0000_0040,  1);
        vecs[9]  = mk(0, 32'h0,          0, 0, 0,  1, 1, 0,  1,  0,   0, 0, 2'b00, 0, 32'h0,          0);
        vecs[10] = mk(0, 32'h0,          0, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b00, 0, 32'h0,          0);
        vecs[11] = mk(1, 32'h4000_0000,  2, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b00, 2, 32'h4000_0000,  0);
        vecs[12] = mk(0, 32'h0,          0, 0, 0,  1, 1, 1,  1,  0,   0, 1, 2'b00, 0, 32'h0,          0);
        vecs[13] = mk(0, 32'h0,          0, 0, 1,  1, 1, 1,  1,  0,   1, 1, 2'b00, 0, 32'h0,          0);
        vecs[14] = mk(0, 32'h0,          0, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b00, 0, 32'h0,          0);
        vecs[15] = mk(1, 32'h2000_0000,  2, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b10, 2, 32'h2000_0000,  0);
        vecs[16] = mk(1, 32'h2000_0000,  0, 0, 1,  1, 1, 1,  1,  0,   1, 0, 2'b00, 0, 32'h2000_0000,  0);
        vecs[17] = mk(0, 32'h0,          0, 0, 1,  1, 1, 1,  0,  0,   1, 0, 2'b00, 0, 32'h0,          0);
        vecs[18] = mk(1, 32'h3000_0000,  3, 0, 1,  1, 0, 1,  1,  0,   1, 0, 2'b10, 3, 32'h3000_0000,  0);
        vecs[19] = mk(0, 32'h0,          0, 0, 0,  1, 0, 1,  1,  0,   0, 0, 2'b10, 3, 32'h3000_0000,  0);
        vecs[20] = mk(0, 32'h0,          0, 0, 0,  1, 1, 1,  1,  0,   0, 0, 2'b10, 3, 32'h3000_0000,  0);
        vecs[21] = mk(0, 32'h0,          0, 0, 1,  1, 1, 1,  1,  1,   1, 1, 2'b00, 0, 32'h0,          0);

        HRESETn = 1'b0;
        HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'd3; HMASTLOCKS = 1'b0;
        hready0 = 1'b1; hready1 = 1'b1; hresp0 = 1'b0;
        drive(vecs[0]);
        #12;
        check("reset hreadyouts", {31'd0, HREADYOUTS}, 32'd1);
        check("reset req", {30'd0, req1, req0}, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        for (int i = 0; i < 22; i++) apply(vecs[i], i);

        // Reset asserted while a transfer is pending must drop it without a clock edge.
        drive(mk(1, 32'h0000_0040, 2, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge HCLK);
        #1;
        HSELS = 1'b0;
        HREADYS = 1'b0;
        #1;
        check("pend before reset req0", {31'd0, req0}, 32'd1);
        check("pend before reset hreadyouts", {31'd0, HREADYOUTS}, 32'd0);
        HRESETn = 1'b0;
        #1;
        check("async reset req0", {31'd0, req0}, 32'd0);
        check("async reset hreadyouts", {31'd0, HREADYOUTS}, 32'd1);
        check("async reset hresps", {31'd0, HRESPS}, 32'd0);
        check("async reset htranso", {30'd0, HTRANSO}, 32'd0);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check("after reset req0", {31'd0, req0}, 32'd0);
        check("after reset hreadyouts", {31'd0, HREADYOUTS}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
